ext_trig_coinc: RTL and testbench

EXT_TRIG_COINC -- requirements
Module: ext_trig_coinc

---
 rtl/ext_trig_pkg.sv | 33 +++
 rtl/ext_trig_coinc_if.sv | 47 ++++
 rtl/ext_trig_edge_finder.sv | 33 +++
 rtl/ext_trig_coinc.sv | 179 +++++++++++++++++
 tb/tb_ext_trig_coinc.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_trig_pkg.sv
// Shared types and constants for the external-trigger coincidence block.
//   trig_mode_e  : coincidence mode as presented on the 2-bit mode input
//   run_state_e  : run-control FSM states
//   PHASE_W      : width of a bit-position (phase) index within one word
//   SAMPLES_PER_CLK : deserialized samples per clk40 per channel
//   popcount8    : number of set bits in an 8-bit vector
package ext_trig_pkg;

  localparam int unsigned PHASE_W         = 5;
  localparam int unsigned SAMPLES_PER_CLK = 32;

  typedef enum logic [1:0] {
    MODE_OR   = 2'd0,
    MODE_AND  = 2'd1,
    MODE_MAJ  = 2'd2,
    MODE_RSVD = 2'd3  // behaves as MODE_OR
  } trig_mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } run_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ext_trig_coinc_if.sv
// Configuration, stimulus and status bundle of ext_trig_coinc.
//   master : drives samples/config/run-control, observes trigger outputs and counters
//   slave  : the coincidence block itself
interface ext_trig_coinc_if #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DELAY_DEPTH = 32,
  parameter int unsigned CNT_W       = 32
);
  localparam int unsigned DLY_W = $clog2(DELAY_DEPTH);

  // Inputs to the block
  logic [N_CH*32-1:0] samples;      // channel c at [c*32 +: 32], bit 31 earliest
  logic [N_CH-1:0]    ch_enable;
  logic [1:0]         mode;
  logic [3:0]         majority;
  logic [DLY_W-1:0]   trig_delay;
  logic [15:0]        deadtime;
  logic [CNT_W-1:0]   max_triggers;
  logic               busy;
  logic               start_run;
  logic               stop_run;

  // Outputs from the block
  logic               running;
  logic               trig_out;
  logic [4:0]         trig_phase;
  logic [N_CH-1:0]    trig_mask;
  logic               trig_delayed;
  logic [CNT_W-1:0]   trig_count;
  logic [CNT_W-1:0]   veto_busy_count;
  logic [CNT_W-1:0]   veto_dead_count;

  modport master (
    output samples, ch_enable, mode, majority, trig_delay, deadtime, max_triggers,
           busy, start_run, stop_run,
    input  running, trig_out, trig_phase, trig_mask, trig_delayed, trig_count,
           veto_busy_count, veto_dead_count
  );

  modport slave (
    input  samples, ch_enable, mode, majority, trig_delay, deadtime, max_triggers,
           busy, start_run, stop_run,
    output running, trig_out, trig_phase, trig_mask, trig_delayed, trig_count,
           veto_busy_count, veto_dead_count
  );

endinterface

// File: rtl/ext_trig_edge_finder.sv
// Rising-edge finder for one channel (purely combinational).
//   last_bit_i : bit 0 of this channel's previous word (the sample just before bit 31)
//   word_i     : current 32-bit word, bit 31 earliest in time
//   hit_o      : any 0->1 transition across {last_bit_i, word_i}
//   phase_o    : position of the earliest transition, 0 = bit 31
module ext_trig_edge_finder
  import ext_trig_pkg::*;
(
  input  logic                       last_bit_i,
  input  logic [SAMPLES_PER_CLK-1:0] word_i,
  output logic                       hit_o,
  output logic [PHASE_W-1:0]         phase_o
);

  logic [SAMPLES_PER_CLK-1:0] prev;
  logic [SAMPLES_PER_CLK-1:0] rise;

  // prev[i] is the sample immediately preceding word_i[i] in time
  assign prev = {last_bit_i, word_i[SAMPLES_PER_CLK-1:1]};
  assign rise = word_i & ~prev;
  assign hit_o = |rise;

  // Ascending scan: the last match is the highest bit, i.e. the earliest sample
  always_comb begin
    phase_o = '0;
    for (int i = 0; i < SAMPLES_PER_CLK; i++) begin
      if (rise[i]) begin
        phase_o = PHASE_W'(SAMPLES_PER_CLK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/ext_trig_coinc.sv
// External-trigger coincidence unit.
//   clk40   : sole clock
//   resetn  : asynchronous active-low reset
//   trig_if : slave side of ext_trig_coinc_if (samples, config, run control in;
//             trigger pulse/phase/mask, delayed trigger, run status and counters out)
// Pipeline: per-channel edge detect registered (stage 1), coincidence decision
// combinational on stage 1, accepted trigger registered -> 2 cycles samples to trig_out.
module ext_trig_coinc
  import ext_trig_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DELAY_DEPTH = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk40,
  input  logic             resetn,
  ext_trig_coinc_if.slave  trig_if
);

  logic [SAMPLES_PER_CLK-1:0] word [N_CH];
  logic [N_CH-1:0]            hit_raw;
  logic [PHASE_W-1:0]         phase_raw [N_CH];

  logic [N_CH-1:0]            last_bit_q;
  logic [N_CH-1:0]            hit_q;
  logic [PHASE_W-1:0]         phase_q [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign word[c] = trig_if.samples[c*SAMPLES_PER_CLK +: SAMPLES_PER_CLK];

    ext_trig_edge_finder u_edge (
      .last_bit_i (last_bit_q[c]),
      .word_i     (word[c]),
      .hit_o      (hit_raw[c]),
      .phase_o    (phase_raw[c])
    );
  end

  // Stage 1: last-bit history (unmasked) and masked per-channel hit/phase
  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      last_bit_q <= '0;
      hit_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        phase_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        last_bit_q[c] <= word[c][0];
        hit_q[c]      <= hit_raw[c] & trig_if.ch_enable[c];
        phase_q[c]    <= trig_if.ch_enable[c] ? phase_raw[c] : '0;
      end
    end
  end

  // Stage 2: coincidence decision and earliest phase
  logic               cand;
  logic               found;
  logic [PHASE_W-1:0] cand_phase;
  logic [3:0]         hit_cnt;
  logic [3:0]         maj_eff;

  always_comb begin
    cand_phase = '0;
    found      = 1'b0;
    // Strict compare keeps the lowest channel on equal phases
    for (int c = 0; c < N_CH; c++) begin
      if (hit_q[c] && (!found || (phase_q[c] < cand_phase))) begin
        cand_phase = phase_q[c];
        found      = 1'b1;
      end
    end
    hit_cnt = popcount8(8'(hit_q));
    maj_eff = (trig_if.majority == 4'd0) ? 4'd1 : trig_if.majority;
    cand    = 1'b0;
    case (trig_mode_e'(trig_if.mode))
      MODE_AND: cand = (hit_q == trig_if.ch_enable) && (trig_if.ch_enable != '0);
      MODE_MAJ: cand = (hit_cnt >= maj_eff);
      default:  cand = |hit_q;
    endcase
  end

  run_state_e       state_q;
  logic [15:0]      dead_q;
  logic [CNT_W-1:0] trig_count_q, veto_busy_q, veto_dead_q;
  logic [CNT_W-1:0] trig_count_d, veto_busy_d, veto_dead_d;
  logic             running, dead, accept, veto_busy, veto_dead;

  assign running   = (state_q == StRun);
  assign dead      = (dead_q != 16'd0);
  assign accept    = cand & running & ~trig_if.busy & ~dead;
  assign veto_busy = cand & running & trig_if.busy;
  assign veto_dead = cand & running & ~trig_if.busy & dead;

  // Saturating increments
  assign trig_count_d = (trig_count_q != '1) ? trig_count_q + CNT_W'(1) : trig_count_q;
  assign veto_busy_d  = (veto_busy_q  != '1) ? veto_busy_q  + CNT_W'(1) : veto_busy_q;
  assign veto_dead_d  = (veto_dead_q  != '1) ? veto_dead_q  + CNT_W'(1) : veto_dead_q;

  // Run-control FSM and run counters
  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      trig_count_q <= '0;
      veto_busy_q  <= '0;
      veto_dead_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // stop_run wins over a simultaneous start_run
          if (trig_if.start_run && !trig_if.stop_run) begin
            state_q      <= StRun;
            trig_count_q <= '0;
            veto_busy_q  <= '0;
            veto_dead_q  <= '0;
          end
        end
        StRun: begin
          if (accept)    trig_count_q <= trig_count_d;
          if (veto_busy) veto_busy_q  <= veto_busy_d;
          if (veto_dead) veto_dead_q  <= veto_dead_d;
          if (trig_if.stop_run) begin
            state_q <= StIdle;
          end else if (accept && (trig_if.max_triggers != '0) &&
                       (trig_count_d == trig_if.max_triggers)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Dead counter, registered trigger outputs and delay line.
  // dly_q[k] holds trig_out as it was k cycles ago.
  logic             trig_out_q;
  logic [4:0]       trig_phase_q;
  logic [N_CH-1:0]  trig_mask_q;
  logic [DELAY_DEPTH-1:1] dly_q;
  logic [DELAY_DEPTH-1:0] tap;

  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      dead_q       <= '0;
      trig_out_q   <= 1'b0;
      trig_phase_q <= '0;
      trig_mask_q  <= '0;
      dly_q        <= '0;
    end else begin
      // Keeps counting down regardless of run state
      if (accept) begin
        dead_q <= trig_if.deadtime;
      end else if (dead) begin
        dead_q <= dead_q - 16'd1;
      end
      trig_out_q <= accept;
      if (accept) begin
        trig_phase_q <= cand_phase;
        trig_mask_q  <= hit_q;
      end
      dly_q[1] <= trig_out_q;
      for (int k = 2; k < DELAY_DEPTH; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  assign tap = {dly_q, trig_out_q};

  assign trig_if.running         = running;
  assign trig_if.trig_out        = trig_out_q;
  assign trig_if.trig_phase      = trig_phase_q;
  assign trig_if.trig_mask       = trig_mask_q;
  assign trig_if.trig_delayed    = tap[trig_if.trig_delay];
  assign trig_if.trig_count      = trig_count_q;
  assign trig_if.veto_busy_count = veto_busy_q;
  assign trig_if.veto_dead_count = veto_dead_q;

endmodule

// File: tb/tb_ext_trig_coinc.sv
module tb_ext_trig_coinc;
  import ext_trig_pkg::*;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned DELAY_DEPTH = 32;
  localparam int unsigned CNT_W       = 32;

  logic clk40  = 1'b0;
  logic resetn = 1'b0;
  always #5 clk40 = ~clk40;

  ext_trig_coinc_if #(.N_CH(N_CH), .DELAY_DEPTH(DELAY_DEPTH), .CNT_W(CNT_W)) tif ();

  ext_trig_coinc #(.N_CH(N_CH), .DELAY_DEPTH(DELAY_DEPTH), .CNT_W(CNT_W)) dut (
    .clk40   (clk40),
    .resetn  (resetn),
    .trig_if (tif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_run;
  int unsigned      m_dead;
  logic [CNT_W-1:0] m_cnt, m_vb, m_vd;
  bit               m_tout;
  int               m_phase;
  logic [N_CH-1:0]  m_mask;
  logic [31:0]      m_prev_word [N_CH];
  bit               p_hit [N_CH];     // edge seen in the previous cycle's word
  int               p_phase [N_CH];
  bit               tout_hist [$];    // trig_out per cycle, newest at back

  // Walk the sample timeline (previous last bit, then bit 31 down to bit 0)
  function automatic void find_edge(input logic prev, input logic [31:0] w,
                                    output bit hit, output int ph);
    bit tl [33];
    tl[0] = prev;
    for (int k = 0; k < 32; k++) tl[k+1] = w[31-k];
    hit = 0;
    ph  = 0;
    for (int k = 0; k < 32; k++) begin
      if (!hit && !tl[k] && tl[k+1]) begin
        hit = 1;
        ph  = k;
      end
    end
  endfunction

  task automatic model_reset();
    m_run = 0; m_dead = 0; m_cnt = '0; m_vb = '0; m_vd = '0;
    m_tout = 0; m_phase = 0; m_mask = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_prev_word[c] = '0; p_hit[c] = 0; p_phase[c] = 0;
    end
    tout_hist.delete();
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1;
  endfunction

  task automatic model_edge();
    int nhit, nen, best_ph, maj, ph;
    bit cand, all_en, acc, vb, vd, dd, h;
    logic [N_CH-1:0] hv;
    logic [31:0] w;
    nhit = 0; nen = 0; best_ph = 99; hv = '0; all_en = 1;
    for (int c = 0; c < N_CH; c++) begin
      if (p_hit[c]) begin
        nhit++;
        hv[c] = 1'b1;
        if (p_phase[c] < best_ph) best_ph = p_phase[c];
      end
      if (tif.ch_enable[c]) begin
        nen++;
        if (!p_hit[c]) all_en = 0;
      end
    end
    case (tif.mode)
      2'd1:    cand = (nen > 0) && all_en;
      2'd2: begin
        maj  = (tif.majority == 4'd0) ? 1 : int'(tif.majority);
        cand = (nhit >= maj);
      end
      default: cand = (nhit > 0);
    endcase
    dd  = (m_dead != 0);
    acc = cand && m_run && !tif.busy && !dd;
    vb  = cand && m_run && tif.busy;
    vd  = cand && m_run && !tif.busy && dd;
    m_tout = acc;
    if (acc) begin
      m_phase = best_ph;
      m_mask  = hv;
    end
    if (acc) m_dead = tif.deadtime;
    else if (dd) m_dead--;
    if (m_run) begin
      if (acc) m_cnt = sat_inc(m_cnt);
      if (vb)  m_vb  = sat_inc(m_vb);
      if (vd)  m_vd  = sat_inc(m_vd);
      if (tif.stop_run) m_run = 0;
      else if (acc && tif.max_triggers != 0 && m_cnt == tif.max_triggers) m_run = 0;
    end else if (tif.start_run && !tif.stop_run) begin
      m_run = 1; m_cnt = '0; m_vb = '0; m_vd = '0;
    end
    tout_hist.push_back(m_tout);
    if (tout_hist.size() > 64) void'(tout_hist.pop_front());
    for (int c = 0; c < N_CH; c++) begin
      w = tif.samples[c*32 +: 32];
      find_edge(m_prev_word[c][0], w, h, ph);
      p_hit[c]       = h && tif.ch_enable[c];
      p_phase[c]     = ph;
      m_prev_word[c] = w;
    end
  endtask

  task automatic check_all();
    int d, n;
    bit exp_dly;
    n = tout_hist.size();
    d = int'(tif.trig_delay);
    exp_dly = (d < n) ? tout_hist[n-1-d] : 1'b0;
    check_eq("running",    tif.running,         m_run);
    check_eq("trig_out",   tif.trig_out,        m_tout);
    check_eq("trig_phase", tif.trig_phase,      m_phase);
    check_eq("trig_mask",  tif.trig_mask,       m_mask);
    check_eq("trig_count", tif.trig_count,      m_cnt);
    check_eq("veto_busy",  tif.veto_busy_count, m_vb);
    check_eq("veto_dead",  tif.veto_dead_count, m_vd);
    check_eq("trig_dly",   tif.trig_delayed,    exp_dly);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk40);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_word(input int c, input logic [31:0] w);
    tif.samples[c*32 +: 32] = w;
  endtask

  task automatic quiet(input int n);
    tif.samples = '0;
    repeat (n) step();
  endtask

  task automatic pulse_start(input bit with_stop);
    tif.start_run = 1'b1;
    tif.stop_run  = with_stop;
    step();
    tif.start_run = 1'b0;
    tif.stop_run  = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case ($urandom % 5)
      0:       return 32'h0;
      1:       return ones;
      2:       return ones >> ($urandom % 32);
      3:       return $urandom;
      default: return ~(ones >> ($urandom % 32));
    endcase
  endfunction

  int pulses, ph_seen, last_acc, last_vd, t0, t1;
  logic [CNT_W-1:0] tc0, vb0;

  initial begin
    tif.samples = '0; tif.ch_enable = 4'b1111; tif.mode = 2'd0; tif.majority = 4'd0;
    tif.trig_delay = '0; tif.deadtime = 16'd0; tif.max_triggers = '0;
    tif.busy = 1'b0; tif.start_run = 1'b0; tif.stop_run = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk40);
    resetn = 1'b1;

    // Single channel edge, OR mode
    tif.ch_enable = 4'b0001;
    pulse_start(1'b0);
    quiet(1);
    set_word(0, 32'h0000_FFFF);
    step();
    set_word(0, 32'h0);
    step();
    check_eq("r028_out",   tif.trig_out,   1);
    check_eq("r028_phase", tif.trig_phase, 16);
    check_eq("r028_mask",  tif.trig_mask,  4'b0001);
    check_eq("r028_count", tif.trig_count, 1);
    quiet(2);

    // Constant-high words after one edge give no further hits
    set_word(0, 32'h0000_00FF);
    step();
    set_word(0, 32'hFFFF_FFFF);
    pulses = 0; ph_seen = -1;
    repeat (6) begin
      step();
      if (tif.trig_out) begin pulses++; ph_seen = tif.trig_phase; end
    end
    check_eq("r029_pulses", pulses, 1);
    check_eq("r029_phase", ph_seen, 24);
    quiet(2);

    // Majority 2 of 4
    tif.mode = 2'd2; tif.majority = 4'd2; tif.ch_enable = 4'b1111;
    set_word(1, 32'hFFFF_FFFF >> 10);
    set_word(3, 32'hFFFF_FFFF >> 4);
    step();
    tif.samples = '0;
    step();
    check_eq("r030_out",   tif.trig_out,   1);
    check_eq("r030_phase", tif.trig_phase, 4);
    check_eq("r030_mask",  tif.trig_mask,  4'b1010);
    quiet(2);
    set_word(1, 32'hFFFF_FFFF >> 10);
    pulses = 0;
    step();
    tif.samples = '0;
    repeat (3) begin step(); if (tif.trig_out) pulses++; end
    check_eq("r030_single", pulses, 0);
    quiet(2);

    // Deadtime spacing, then busy veto
    tif.mode = 2'd0; tif.ch_enable = 4'b0001; tif.deadtime = 16'd5;
    set_word(0, 32'h0000_FFFF);
    last_acc = -1; last_vd = 0;
    repeat (20) begin
      step();
      if (tif.trig_out) begin
        if (last_acc >= 0) begin
          check_eq("r031_space", cyc - last_acc, 6);
          check_eq("r031_vdead", int'(tif.veto_dead_count) - last_vd, 5);
        end
        last_acc = cyc;
        last_vd  = int'(tif.veto_dead_count);
      end
    end
    tc0 = tif.trig_count; vb0 = tif.veto_busy_count;
    tif.busy = 1'b1;
    repeat (5) step();
    check_eq("r031_busy", tif.veto_busy_count - vb0, 5);
    check_eq("r031_tcnt", tif.trig_count, tc0);
    tif.busy = 1'b0;
    tif.deadtime = 16'd0;
    quiet(8);

    // Run limit of three triggers
    tif.stop_run = 1'b1; step(); tif.stop_run = 1'b0;
    tif.max_triggers = 3;
    set_word(0, 32'h0000_FFFF);
    pulse_start(1'b0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tif.trig_out) pulses++;
      if (!tif.running) break;
    end
    check_eq("r032_run",    tif.running, 0);
    check_eq("r032_count",  tif.trig_count, 3);
    check_eq("r032_pulses", pulses, 3);
    repeat (3) begin step(); if (tif.trig_out) pulses++; end
    check_eq("r032_after", pulses, 3);
    tif.max_triggers = 0;
    quiet(2);
    pulse_start(1'b1);
    check_eq("r032_both", tif.running, 0);

    // Delayed output, then asynchronous reset inside deadtime
    tif.trig_delay = 5'd7; tif.deadtime = 16'd20;
    pulse_start(1'b0);
    quiet(10);
    set_word(0, 32'h0000_FFFF);
    step();
    tif.samples = '0;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tif.trig_out && t0 < 0) t0 = cyc;
      if (tif.trig_delayed && t1 < 0) t1 = cyc;
      if (t1 >= 0) break;
    end
    check_eq("r033_delay", t1 - t0, 7);
    #3 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("r033_rst_phase", tif.trig_phase, 0);
    @(negedge clk40);
    resetn = 1'b1;

    // Randomized segments; config changes only after quiet cycles
    for (int seg = 0; seg < 60; seg++) begin
      quiet(2);
      tif.ch_enable    = 4'($urandom % 16);
      tif.mode         = 2'($urandom % 4);
      tif.majority     = 4'($urandom % 6);
      tif.deadtime     = 16'($urandom % 8);
      tif.max_triggers = CNT_W'($urandom % 6);
      for (int i = 0; i < 40; i++) begin
        for (int c = 0; c < N_CH; c++) set_word(c, rand_word());
        tif.busy       = ($urandom % 5) == 0;
        tif.start_run  = ($urandom % 8) == 0;
        tif.stop_run   = ($urandom % 30) == 0;
        if (($urandom % 10) == 0) tif.trig_delay = 5'($urandom % 32);
        step();
      end
      tif.busy = 1'b0; tif.start_run = 1'b0; tif.stop_run = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
